// File: rtl/guess_game_pkg.sv
// Shared types for the number-guessing game core: FSM states, hint and result codes,
// and the single-digit BCD type with its wrap-around increment.
package guess_game_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    CHECK,
    WIN,
    LOSE
  } game_state_e;

  typedef enum logic [1:0] {
    HINT_NONE    = 2'b00,
    HINT_LOW     = 2'b01,
    HINT_HIGH    = 2'b10,
    HINT_CORRECT = 2'b11
  } hint_e;

  typedef enum logic [1:0] {
    RESULT_NONE = 2'b00,
    RESULT_WIN  = 2'b01,
    RESULT_LOSE = 2'b10
  } result_e;

  function automatic bcd_t bcd_inc(input bcd_t d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/guess_game_if.sv
// Player-side and display-side signal bundle of the guessing game core, plus
// the FSM state exposed for observation.
interface guess_game_if #(
  parameter int NUM_DIGITS = 3,
  parameter int TIME_W     = 8,
  parameter int SCORE_W    = 12
);
  import guess_game_pkg::*;

  // Inputs are single-cycle pulses with no back-pressure: a pulse is consumed on
  // the clock edge where it is high, or dropped if the current state ignores it.
  logic                    tick_1hz;
  logic [NUM_DIGITS-1:0]   digit_inc;
  logic                    confirm;
  logic [4*NUM_DIGITS-1:0] target_bcd;

  logic [4*NUM_DIGITS-1:0] guess_bcd;
  logic [1:0]              hint;
  logic [3:0]              level;
  logic [3:0]              guesses_left;
  logic [TIME_W-1:0]       time_left;
  logic [1:0]              result;
  logic                    new_round;
  logic [SCORE_W-1:0]      score;
  game_state_e             state;

  modport master (
    output tick_1hz, digit_inc, confirm, target_bcd,
    input  guess_bcd, hint, level, guesses_left, time_left, result, new_round, score, state
  );

  modport slave (
    input  tick_1hz, digit_inc, confirm, target_bcd,
    output guess_bcd, hint, level, guesses_left, time_left, result, new_round, score, state
  );

endinterface

// File: rtl/guess_bcd_compare.sv
// Combinational magnitude compare of two BCD numbers over the low `level` digits;
// digits at or above the active level are masked to zero on both sides.
module guess_bcd_compare
  import guess_game_pkg::*;
#(
  parameter int NUM_DIGITS = 3
) (
  input  logic [4*NUM_DIGITS-1:0] guess,
  input  logic [4*NUM_DIGITS-1:0] target,
  input  logic [3:0]              level,
  output hint_e                   hint
);

  logic [4*NUM_DIGITS-1:0] guess_m;
  logic [4*NUM_DIGITS-1:0] target_m;

  // With valid BCD digits the packed vector order equals decimal order, MS digit first.
  always_comb begin
    guess_m  = '0;
    target_m = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i < int'(level)) begin
        guess_m[4*i +: 4]  = guess[4*i +: 4];
        target_m[4*i +: 4] = target[4*i +: 4];
      end
    end
    if (guess_m == target_m) begin
      hint = HINT_CORRECT;
    end else if (guess_m < target_m) begin
      hint = HINT_LOW;
    end else begin
      hint = HINT_HIGH;
    end
  end

endmodule

// File: rtl/guess_game_engine.sv
// Number-guessing game core: digit entry, guess checking, level progression, guess budget
// and countdown timer. Optional scoring is enabled with the GUESS_SCORE_EN macro.
module guess_game_engine
  import guess_game_pkg::*;
#(
  parameter int NUM_DIGITS     = 3,
  parameter int MAX_GUESSES    = 5,
  parameter int TIME_PER_DIGIT = 20,
  parameter int TIME_W         = 8,
  parameter int SCORE_W        = 12
) (
  input logic         clk,
  input logic         rst,
  guess_game_if.slave bus
);

  game_state_e             state_q;
  logic [4*NUM_DIGITS-1:0] guess_q;
  logic [4*NUM_DIGITS-1:0] snap_q;
  logic [4*NUM_DIGITS-1:0] target_q;
  hint_e                   hint_q;
  logic [3:0]              level_q;
  logic [3:0]              guesses_q;
  logic [TIME_W-1:0]       time_q;
  result_e                 result_q;
  logic                    new_round_q;

  hint_e                   cmp_hint;
  logic [TIME_W-1:0]       time_dec;
  logic [TIME_W-1:0]       load_time;
  logic                    timeout;

  guess_bcd_compare #(.NUM_DIGITS(NUM_DIGITS)) u_compare (
    .guess  (snap_q),
    .target (target_q),
    .level  (level_q),
    .hint   (cmp_hint)
  );

  assign time_dec  = (time_q != '0) ? time_q - TIME_W'(1) : '0;
  assign load_time = TIME_W'(TIME_PER_DIGIT * int'(level_q));
  assign timeout   = bus.tick_1hz && (time_q <= TIME_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      guess_q     <= '0;
      snap_q      <= '0;
      target_q    <= '0;
      hint_q      <= HINT_NONE;
      level_q     <= 4'd1;
      guesses_q   <= 4'(MAX_GUESSES);
      time_q      <= '0;
      result_q    <= RESULT_NONE;
      new_round_q <= 1'b0;
    end else begin
      new_round_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.confirm) begin
            state_q     <= LOAD;
            new_round_q <= 1'b1;
          end
        end
        LOAD: begin
          target_q  <= bus.target_bcd;
          guess_q   <= '0;
          hint_q    <= HINT_NONE;
          guesses_q <= 4'(MAX_GUESSES);
          time_q    <= load_time;
          state_q   <= PLAY;
        end
        PLAY: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.digit_inc[i] && (i < int'(level_q))) begin
              guess_q[4*i +: 4] <= bcd_inc(guess_q[4*i +: 4]);
            end
          end
          if (bus.tick_1hz) begin
            time_q <= time_dec;
          end
          // Running out of time wins over a confirm arriving on the same edge.
          if (timeout) begin
            state_q  <= LOSE;
            result_q <= RESULT_LOSE;
          end else if (bus.confirm) begin
            snap_q  <= guess_q;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (bus.tick_1hz) begin
            time_q <= time_dec;
          end
          hint_q <= cmp_hint;
          if (cmp_hint == HINT_CORRECT) begin
            if (level_q < 4'(NUM_DIGITS)) begin
              level_q     <= level_q + 4'd1;
              state_q     <= LOAD;
              new_round_q <= 1'b1;
            end else begin
              state_q  <= WIN;
              result_q <= RESULT_WIN;
            end
          end else begin
            if (guesses_q != 4'd0) begin
              guesses_q <= guesses_q - 4'd1;
            end
            if ((guesses_q <= 4'd1) || timeout) begin
              state_q  <= LOSE;
              result_q <= RESULT_LOSE;
            end else begin
              state_q <= PLAY;
            end
          end
        end
        WIN, LOSE: begin
          if (bus.confirm) begin
            state_q  <= IDLE;
            level_q  <= 4'd1;
            result_q <= RESULT_NONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef GUESS_SCORE_EN
  localparam int SUM_W = SCORE_W + TIME_W + 1;

  logic [SCORE_W-1:0] score_q;
  logic [SUM_W-1:0]   score_sum;

  // Bonus uses the budget and time still on the clock when the correct guess is judged.
  assign score_sum = SUM_W'(score_q) + SUM_W'(guesses_q) + SUM_W'(time_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_q <= '0;
    end else if ((state_q == CHECK) && (cmp_hint == HINT_CORRECT)) begin
      score_q <= (score_sum > SUM_W'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    end else if (((state_q == WIN) || (state_q == LOSE)) && bus.confirm) begin
      score_q <= '0;
    end
  end

  assign bus.score = score_q;
`else
  assign bus.score = {SCORE_W{1'b0}};
`endif

  assign bus.guess_bcd    = guess_q;
  assign bus.hint         = hint_q;
  assign bus.level        = level_q;
  assign bus.guesses_left = guesses_q;
  assign bus.time_left    = time_q;
  assign bus.result       = result_q;
  assign bus.new_round    = new_round_q;
  assign bus.state        = state_q;

endmodule
